// File: rtl/vram_arbiter.sv
// vram_arbiter: two-requester round-robin arbiter in front of a single
// 8-bit VRAM port, with a fill engine that takes the port over and writes one
// byte value to every location.
module vram_arbiter #(
  parameter int DEPTH = 57600,
  parameter int AW    = 24
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          r0_req,
  input  logic          r0_we,
  input  logic [AW-1:0] r0_addr,
  input  logic [7:0]    r0_wdata,
  output logic          r0_gnt,
  output logic          r0_rvalid,
  input  logic          r1_req,
  input  logic          r1_we,
  input  logic [AW-1:0] r1_addr,
  input  logic [7:0]    r1_wdata,
  output logic          r1_gnt,
  output logic          r1_rvalid,
  output logic [7:0]    rdata,
  input  logic          fill_start,
  input  logic [7:0]    fill_value,
  output logic          fill_busy,
  output logic          fill_done,
  output logic          addr_err,
  output logic [AW-1:0] ram_addr,
  output logic [7:0]    ram_din,
  output logic          ram_we,
  input  logic [7:0]    ram_dout
);

  typedef enum logic {IDLE = 1'b0, FILL = 1'b1} state_t;

  localparam logic [AW-1:0] LP_DEPTH = AW'(DEPTH);
  localparam logic [AW-1:0] LP_LAST  = AW'(DEPTH - 1);

  state_t        r_state;
  state_t        w_state_next;
  logic [AW-1:0] r_fill_cnt;
  logic [7:0]    r_fill_value;
  logic          r_last_gnt;   // 1: r1 was granted most recently, so r0 wins next conflict
  logic          r_r0_rvalid;
  logic          r_r1_rvalid;
  logic          r_rd_err;     // pending read was out of range, return zero
  logic          r_fill_done;

  logic          w_gnt0;
  logic          w_gnt1;
  logic          w_sel_we;
  logic          w_sel_err;
  logic          w_fill_last;

  assign w_fill_last = (r_state == FILL) && (r_fill_cnt == LP_LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state logic: fill_start is only honoured from IDLE
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (fill_start)  w_state_next = FILL;
      FILL:    if (w_fill_last) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Output logic: grants and RAM port mux; everything quiet while in reset
  always_comb begin
    w_gnt0    = 1'b0;
    w_gnt1    = 1'b0;
    w_sel_we  = 1'b0;
    w_sel_err = 1'b0;
    ram_addr  = '0;
    ram_din   = 8'h00;
    ram_we    = 1'b0;
    addr_err  = 1'b0;
    if (rst_n) begin
      case (r_state)
        IDLE: begin
          w_gnt0 = r0_req && (!r1_req || r_last_gnt);
          w_gnt1 = r1_req && (!r0_req || !r_last_gnt);
          if (w_gnt0) begin
            ram_addr  = r0_addr;
            ram_din   = r0_wdata;
            w_sel_we  = r0_we;
            w_sel_err = (r0_addr >= LP_DEPTH);
          end else if (w_gnt1) begin
            ram_addr  = r1_addr;
            ram_din   = r1_wdata;
            w_sel_we  = r1_we;
            w_sel_err = (r1_addr >= LP_DEPTH);
          end
          ram_we   = w_sel_we && !w_sel_err;
          addr_err = w_sel_err;
        end
        FILL: begin
          ram_addr = r_fill_cnt;
          ram_din  = r_fill_value;
          ram_we   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Fill counter and latched fill byte
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fill_cnt   <= '0;
      r_fill_value <= 8'h00;
    end else if (r_state == IDLE && fill_start) begin
      r_fill_cnt   <= '0;
      r_fill_value <= fill_value;
    end else if (r_state == FILL) begin
      r_fill_cnt <= w_fill_last ? '0 : r_fill_cnt + AW'(1);
    end
  end

  // Round-robin pointer, read-valid pipeline and fill-done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_gnt  <= 1'b1;
      r_r0_rvalid <= 1'b0;
      r_r1_rvalid <= 1'b0;
      r_rd_err    <= 1'b0;
      r_fill_done <= 1'b0;
    end else begin
      if (w_gnt0)      r_last_gnt <= 1'b0;
      else if (w_gnt1) r_last_gnt <= 1'b1;
      r_r0_rvalid <= w_gnt0 && !w_sel_we;
      r_r1_rvalid <= w_gnt1 && !w_sel_we;
      r_rd_err    <= (w_gnt0 || w_gnt1) && !w_sel_we && w_sel_err;
      r_fill_done <= w_fill_last;
    end
  end

  assign r0_gnt    = w_gnt0;
  assign r1_gnt    = w_gnt1;
  assign r0_rvalid = r_r0_rvalid;
  assign r1_rvalid = r_r1_rvalid;
  assign rdata     = ((r_r0_rvalid || r_r1_rvalid) && !r_rd_err) ? ram_dout : 8'h00;
  assign fill_busy = (r_state == FILL);
  assign fill_done = r_fill_done;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: directed scenarios plus a cycle-by-cycle
// behavioural model (memory image, who-won-last, pending read, fill progress).
module tb_vram_arbiter;

  localparam int DEPTH = 16;
  localparam int AW    = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          r0_req, r0_we, r1_req, r1_we;
  logic [AW-1:0] r0_addr, r1_addr;
  logic [7:0]    r0_wdata, r1_wdata;
  logic          r0_gnt, r0_rvalid, r1_gnt, r1_rvalid;
  logic [7:0]    rdata;
  logic          fill_start;
  logic [7:0]    fill_value;
  logic          fill_busy, fill_done, addr_err;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_din;
  logic          ram_we;
  logic [7:0]    ram_dout;

  int checks = 0;
  int errors = 0;

  vram_arbiter #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid),
    .rdata(rdata), .fill_start(fill_start), .fill_value(fill_value),
    .fill_busy(fill_busy), .fill_done(fill_done), .addr_err(addr_err),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // VRAM: registered read; location 16 (out of range) holds junk that must never reach rdata
  logic [7:0] b_mem [0:255];
  bit         ram_ready = 1'b0;
  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < 256; i++) b_mem[i] <= (i == 16) ? 8'h77 : 8'h00;
      ram_ready <= 1'b1;
      ram_dout  <= 8'h00;
    end else begin
      if (ram_we) b_mem[ram_addr] <= ram_din;
      ram_dout <= b_mem[ram_addr];
    end
  end

  // Behavioural model
  logic [7:0] m_mem [0:DEPTH-1];
  bit         m_inited = 1'b0;
  bit         m_filling;
  int         m_fill_idx;
  logic [7:0] m_fill_val;
  int         m_last;       // requester granted most recently
  int         m_pend;       // requester owed read data next cycle, -1 none
  bit         m_pend_err;
  logic [7:0] m_pend_data;
  bit         m_done;

  always @(negedge clk) begin
    int         win, a;
    bit         we, err;
    logic [7:0] wd;
    logic [7:0] exp_rdata;
    if (!m_inited) begin
      for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h00;
      m_inited = 1'b1;
    end
    if (!rst_n) begin
      chk("rst_r0_gnt", r0_gnt, 0);
      chk("rst_r1_gnt", r1_gnt, 0);
      chk("rst_r0_rvalid", r0_rvalid, 0);
      chk("rst_r1_rvalid", r1_rvalid, 0);
      chk("rst_fill_busy", fill_busy, 0);
      chk("rst_fill_done", fill_done, 0);
      chk("rst_addr_err", addr_err, 0);
      chk("rst_ram_we", ram_we, 0);
      m_filling = 0; m_fill_idx = 0; m_last = 1; m_pend = -1; m_done = 0;
      m_pend_err = 0; m_pend_data = 8'h00; m_fill_val = 8'h00;
    end else begin
      exp_rdata = (m_pend >= 0 && !m_pend_err) ? m_pend_data : 8'h00;
      chk("m_fill_busy", fill_busy, m_filling);
      chk("m_fill_done", fill_done, m_done);
      chk("m_r0_rvalid", r0_rvalid, m_pend == 0);
      chk("m_r1_rvalid", r1_rvalid, m_pend == 1);
      chk("m_rdata", rdata, exp_rdata);
      m_done = 0;
      m_pend = -1;
      if (m_filling) begin
        chk("m_fill_gnt0", r0_gnt, 0);
        chk("m_fill_gnt1", r1_gnt, 0);
        chk("m_fill_we", ram_we, 1);
        chk("m_fill_addr", ram_addr, m_fill_idx);
        chk("m_fill_din", ram_din, m_fill_val);
        chk("m_fill_err", addr_err, 0);
        m_mem[m_fill_idx] = m_fill_val;
        m_fill_idx++;
        if (m_fill_idx == DEPTH) begin
          m_filling = 0;
          m_done    = 1;
        end
      end else begin
        if (r0_req && r1_req) win = (m_last == 1) ? 0 : 1;
        else if (r0_req)      win = 0;
        else if (r1_req)      win = 1;
        else                  win = -1;
        a   = (win == 0) ? int'(r0_addr) : (win == 1) ? int'(r1_addr) : 0;
        we  = (win == 0) ? r0_we : (win == 1) ? r1_we : 1'b0;
        wd  = (win == 0) ? r0_wdata : (win == 1) ? r1_wdata : 8'h00;
        err = (win >= 0) && (a >= DEPTH);
        chk("m_gnt0", r0_gnt, win == 0);
        chk("m_gnt1", r1_gnt, win == 1);
        chk("m_addr_err", addr_err, err);
        chk("m_ram_we", ram_we, we && !err);
        chk("m_ram_addr", ram_addr, a);
        chk("m_ram_din", ram_din, wd);
        if (win >= 0) begin
          m_last = win;
          if (!we) begin
            m_pend      = win;
            m_pend_err  = err;
            m_pend_data = err ? 8'h00 : m_mem[a];
          end else if (!err) begin
            m_mem[a] = wd;
          end
        end
        if (fill_start) begin
          m_filling  = 1;
          m_fill_idx = 0;
          m_fill_val = fill_value;
        end
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int busy_cnt, done_cnt, r1_during, saw_rv;
    rst_n = 1'b0;
    r0_req = 0; r0_we = 0; r0_addr = '0; r0_wdata = 8'h00;
    r1_req = 0; r1_we = 0; r1_addr = '0; r1_wdata = 8'h00;
    fill_start = 0; fill_value = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Both requesting: r0, r1, r0, r1
    r0_req = 1; r1_req = 1; r0_addr = 8'd1; r1_addr = 8'd2;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rr_gnt0", r0_gnt, (k % 2) == 0);
      chk("rr_gnt1", r1_gnt, (k % 2) == 1);
      chk("rr_not_both", r0_gnt & r1_gnt, 0);
      $display("rr cycle %0d gnt0=%0b gnt1=%0b", k, r0_gnt, r1_gnt);
      step();
    end
    r0_req = 0; r1_req = 0;

    // r0 write 5 <- A5, then read back
    r0_req = 1; r0_we = 1; r0_addr = 8'd5; r0_wdata = 8'hA5;
    @(negedge clk); chk("wr5_gnt", r0_gnt, 1); chk("wr5_we", ram_we, 1);
    $display("r0 write addr=5 data=a5 gnt=%0b", r0_gnt);
    step(); r0_we = 0;
    @(negedge clk); chk("rd5_gnt", r0_gnt, 1);
    step(); r0_req = 0;
    @(negedge clk); chk("rd5_rvalid", r0_rvalid, 1); chk("rd5_rdata", rdata, 8'hA5);
    $display("r0 read addr=5 rvalid=%0b rdata=%02h", r0_rvalid, rdata);

    // Out-of-range write and read at address DEPTH
    step(); r0_req = 1; r0_we = 1; r0_addr = 8'(DEPTH); r0_wdata = 8'hFF;
    @(negedge clk); chk("oor_wr_gnt", r0_gnt, 1); chk("oor_wr_err", addr_err, 1);
    chk("oor_wr_we", ram_we, 0);
    step(); r0_we = 0;
    @(negedge clk); chk("oor_rd_gnt", r0_gnt, 1); chk("oor_rd_err", addr_err, 1);
    step(); r0_req = 0;
    @(negedge clk); chk("oor_rd_rvalid", r0_rvalid, 1); chk("oor_rd_rdata", rdata, 8'h00);
    chk("oor_err_pulse", addr_err, 0);
    $display("r0 read addr=%0d rvalid=%0b rdata=%02h", DEPTH, r0_rvalid, rdata);

    // Fill with 3C while r1 waits to read 15; a restart attempt mid-fill is ignored
    step(); fill_value = 8'h3C; fill_start = 1;
    step(); fill_start = 0; fill_value = 8'h00; r1_req = 1; r1_we = 0; r1_addr = 8'd15;
    busy_cnt = 0; done_cnt = 0; r1_during = 0; saw_rv = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (fill_busy) begin
        chk("fill_addr_seq", ram_addr, busy_cnt);
        busy_cnt++;
        if (r1_gnt) r1_during++;
      end
      if (fill_done) begin
        done_cnt++;
        chk("fill_r1_first", r1_gnt, 1);
      end
      if (r1_rvalid) begin
        saw_rv = 1;
        chk("fill_rd15", rdata, 8'h3C);
      end
      step();
      if (!fill_busy && done_cnt > 0) r1_req = 0;
      fill_start = (c == 4);
      fill_value = (c == 4) ? 8'h11 : 8'h00;
    end
    chk("fill_busy_cycles", busy_cnt, DEPTH);
    chk("fill_done_count", done_cnt, 1);
    chk("fill_r1_gnt_during", r1_during, 0);
    chk("fill_rd15_seen", saw_rv, 1);
    $display("fill 3c busy=%0d done=%0d", busy_cnt, done_cnt);

    // Reset during fill cycle 7
    fill_value = 8'h5A; fill_start = 1;
    step(); fill_start = 0;
    repeat (7) step();
    chk("pre_rst_addr", ram_addr, 7);
    rst_n = 0;
    @(negedge clk); chk("rst_mid_busy", fill_busy, 0);
    step(); rst_n = 1; r0_req = 1; r0_we = 0; r0_addr = 8'd3;
    @(negedge clk); chk("post_rst_gnt", r0_gnt, 1);
    step(); r0_addr = 8'd7;
    @(negedge clk); chk("post_rst_rd3", rdata, 8'h5A);
    step(); r0_req = 0;
    @(negedge clk); chk("post_rst_rd7", rdata, 8'h3C);
    done_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (fill_done) done_cnt++;
      step();
    end
    chk("rst_no_done", done_cnt, 0);
    $display("reset mid-fill read3=5a read7=3c");

    // Single requester full throughput, then read granted in the fill_start cycle
    r1_req = 1; r1_we = 1;
    for (int k = 1; k <= 3; k++) begin
      r1_addr = 8'(k); r1_wdata = 8'(8'h10 + k);
      @(negedge clk); chk("single_gnt", r1_gnt, 1);
      $display("r1 write addr=%0d data=%02h", k, r1_wdata);
      step();
    end
    r1_req = 0; r1_we = 0;
    r0_req = 1; r0_addr = 8'd2; fill_start = 1; fill_value = 8'h99;
    @(negedge clk); chk("fs_gnt", r0_gnt, 1);
    step(); r0_req = 0; fill_start = 0;
    @(negedge clk); chk("fs_rvalid", r0_rvalid, 1); chk("fs_rdata", rdata, 8'h12);
    chk("fs_busy", fill_busy, 1);
    repeat (DEPTH + 3) step();
    @(negedge clk); chk("end_idle", fill_busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
